queue_ctrl: RTL and testbench
=============================

QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 Parameter SERVICE_TICKS, default 3: tick pulses a teller spends serving one customer; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 arrive  input  1  one-cycle pulse; one customer requests to join the queue.
REQ-005 tick  input  1  one-cycle time-base pulse for service timers.
REQ-006 tcount_cfg  input  2  requested number of tellers; 0 is treated as 1.
REQ-007 pcount  output  3  customers currently waiting, 0..7.
REQ-008 tcount  output  2  active teller count, 1..3.
REQ-009 index  output  5  {tcount, pcount}; this is the wait-time ROM address.
REQ-010 ef  output  1  queue empty, pcount==0.
REQ-011 ff  output  1  queue full, pcount==7.
REQ-012 busy  output  3  bit i high while teller i is serving.
REQ-013 serve  output  1  one-cycle pulse; a customer was dispatched.
REQ-014 serve_id  output  2  teller index for the current serve pulse; holds its last value otherwise.
REQ-015 reject  output  1  one-cycle pulse; an arrival was dropped because the queue was full.

Function
REQ-016 All outputs are registered or decoded only from registers; no combinational path from input to output.
REQ-017 Teller i is enabled iff i < tcount; a disabled teller is never dispatched.
REQ-018 Dispatch condition, evaluated on current register state:
- pcount > 0, and
- at least one enabled teller has busy[i]==0.
REQ-019 At most one dispatch per cycle.
REQ-020 On the edge where dispatch occurs:
- serve=1 and serve_id=i;
- busy[i] sets to 1;
- teller i's timer loads SERVICE_TICKS;
- pcount decrements, subject to REQ-023.
REQ-021 Teller selection is round-robin. The search starts at rr_ptr and wraps modulo tcount; after dispatching to teller i, rr_ptr becomes (i+1) mod tcount.
REQ-022 Arrival handling, when arrive=1 and no dispatch occurs:
- pcount < 7: pcount increments.
- pcount == 7: pcount holds and reject pulses for one cycle.
REQ-023 When arrive and dispatch occur in the same cycle, pcount is unchanged and reject=0, including when pcount==7.
REQ-024 A busy teller's timer decrements by 1 on each tick. When tick=1 and the timer equals 1:
- the timer becomes 0 and busy[i] clears on that edge;
- the teller is dispatchable from the following cycle.
REQ-025 A timer does not decrement in the cycle it is loaded.
REQ-026 tick has no effect on idle tellers.
REQ-027 tcount_cfg is latched into tcount only in a cycle where busy==0 and pcount==0; otherwise tcount holds. When tcount changes, rr_ptr resets to 0.
REQ-028 ef and ff are decoded directly from pcount, so they change on the same edge as pcount.

Reset
REQ-029 On a clk edge with reset=1, the following registers load: pcount=0, tcount=1, busy=0, all timers=0, rr_ptr=0, serve=0, serve_id=0, reject=0.
REQ-030 The resulting outputs are ef=1, ff=0, index=5'b01000.
REQ-031 Reset overrides arrive, tick and tcount_cfg in the same cycle.
REQ-032 Reset mid-service abandons every customer and every in-progress timer; no serve pulse follows the reset.

Verification
REQ-033 Scenario: reset, then tcount_cfg=2 held; 3 arrive pulses on consecutive cycles with tick=0.
- Response: serve_id=0 then serve_id=1; pcount peaks at 1 and ends at 1; busy=3'b011.
REQ-034 Scenario: tcount=1, SERVICE_TICKS=3; 8 arrivals, then 1 more arrival while ff=1 and teller 0 is busy.
- Response: the final arrival gives reject=1 and pcount stays 7.
- 3 ticks later, busy[0] clears and the next cycle gives serve=1 with pcount=6.
REQ-035 Scenario: pcount=7, teller free; arrive=1 in the dispatch cycle.
- Response: serve=1, reject=0, pcount stays 7, ff stays 1.
REQ-036 Scenario: tcount=3, all tellers idle; 6 arrivals, each completing before the next.
- Response: serve_id sequence is 0,1,2,0,1,2.
REQ-037 Scenario: tcount_cfg changed 1->3 while busy[0]=1.
- Response: tcount stays 1 until busy==0 and pcount==0, then index[4:3]=2'b11.
REQ-038 Scenario: reset asserted while busy=3'b111 and pcount=4.
- Response: next cycle busy=0, pcount=0, ef=1, index=5'b01000, no serve pulse.

Source files
------------

// File: rtl/queue_ctrl_if.sv
// Customer queue controller bus.
// Inputs from the environment, registered status back out.
interface queue_ctrl_if;
    logic       arrive;
    logic       tick;
    logic [1:0] tcount_cfg;
    logic [2:0] pcount;
    logic [1:0] tcount;
    logic [4:0] index;
    logic       ef;
    logic       ff;
    logic [2:0] busy;
    logic       serve;
    logic [1:0] serve_id;
    logic       reject;

    modport slave (
        input  arrive, tick, tcount_cfg,
        output pcount, tcount, index, ef, ff,
        output busy, serve, serve_id, reject
    );

    modport master (
        output arrive, tick, tcount_cfg,
        input  pcount, tcount, index, ef, ff,
        input  busy, serve, serve_id, reject
    );
endinterface

// File: rtl/queue_ctrl.sv
// Waiting-line controller: 7-deep customer count,
// up to 3 tellers served round-robin with tick timers.
module queue_ctrl #(
    parameter int SERVICE_TICKS = 3
) (
    input  logic         clk,
    input  logic         reset,
    queue_ctrl_if.slave  bus
);

    logic [2:0] pcount_q;
    logic [1:0] tcount_q;
    logic [2:0] busy_q;
    logic [3:0] timer_q [3];
    logic [1:0] rr_q;
    logic       serve_q;
    logic [1:0] sid_q;
    logic       reject_q;

    logic       found;
    logic [1:0] pick;
    logic [2:0] idx;
    logic [3:0] busy_ext;
    logic       dispatch;
    logic [1:0] pick_nxt;
    logic [1:0] cfg_eff;

    assign busy_ext = {1'b1, busy_q};
    assign cfg_eff  = (bus.tcount_cfg == 2'd0) ? 2'd1 : bus.tcount_cfg;
    assign pick_nxt = pick + 2'd1;

    // Round-robin search for the first idle enabled teller from rr_q.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= {1'b0, tcount_q})
                idx = idx - {1'b0, tcount_q};
            if (!found && 2'(k) < tcount_q && !busy_ext[idx[1:0]]) begin
                found = 1'b1;
                pick  = idx[1:0];
            end
        end
        dispatch = found && (pcount_q != 3'd0);
    end

    // Queue count, teller timers, round-robin pointer and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q <= 3'd0;
            tcount_q <= 2'd1;
            busy_q   <= 3'd0;
            rr_q     <= 2'd0;
            serve_q  <= 1'b0;
            sid_q    <= 2'd0;
            reject_q <= 1'b0;
            for (int i = 0; i < 3; i++)
                timer_q[i] <= 4'd0;
        end else begin
            serve_q  <= dispatch;
            reject_q <= 1'b0;
            if (dispatch) begin
                sid_q <= pick;
                rr_q  <= (pick_nxt == tcount_q) ? 2'd0 : pick_nxt;
                if (!bus.arrive)
                    pcount_q <= pcount_q - 3'd1;
            end else if (bus.arrive) begin
                if (pcount_q == 3'd7)
                    reject_q <= 1'b1;
                else
                    pcount_q <= pcount_q + 3'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (dispatch && pick == 2'(i)) begin
                    timer_q[i] <= 4'(SERVICE_TICKS);
                    busy_q[i]  <= 1'b1;
                end else if (bus.tick && busy_q[i]) begin
                    timer_q[i] <= timer_q[i] - 4'd1;
                    if (timer_q[i] == 4'd1)
                        busy_q[i] <= 1'b0;
                end
            end
            // Teller count may only change with nobody waiting or served.
            if (busy_q == 3'd0 && pcount_q == 3'd0) begin
                tcount_q <= cfg_eff;
                if (cfg_eff != tcount_q)
                    rr_q <= 2'd0;
            end
        end
    end

    assign bus.pcount   = pcount_q;
    assign bus.tcount   = tcount_q;
    assign bus.index    = {tcount_q, pcount_q};
    assign bus.ef       = (pcount_q == 3'd0);
    assign bus.ff       = (pcount_q == 3'd7);
    assign bus.busy     = busy_q;
    assign bus.serve    = serve_q;
    assign bus.serve_id = sid_q;
    assign bus.reject   = reject_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl: directed scenarios plus a
// randomized run against a behavioural queue model.
module tb_queue_ctrl;

    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    queue_ctrl_if bus ();

    queue_ctrl #(.SERVICE_TICKS(ST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: waiting count, remaining service per teller.
    int m_p, m_t, m_rr, m_sid;
    int m_rem [3];
    bit m_serve, m_rej;

    task automatic model_step(input bit r, input bit a, input bit t, input int c);
        int  pick;
        bit  idle, latch;
        if (r) begin
            m_p = 0; m_t = 1; m_rr = 0; m_sid = 0;
            m_serve = 0; m_rej = 0;
            for (int i = 0; i < 3; i++) m_rem[i] = 0;
            return;
        end
        idle = (m_rem[0] == 0) && (m_rem[1] == 0) && (m_rem[2] == 0);
        latch = idle && (m_p == 0);
        pick = -1;
        if (m_p > 0)
            for (int k = 0; k < m_t; k++)
                if (pick < 0 && m_rem[(m_rr + k) % m_t] == 0)
                    pick = (m_rr + k) % m_t;
        for (int i = 0; i < 3; i++)
            if (t && m_rem[i] > 0) m_rem[i]--;
        m_rej = 0;
        m_serve = (pick >= 0);
        if (pick >= 0) begin
            m_rem[pick] = ST;
            m_sid = pick;
            m_rr = (pick + 1) % m_t;
            if (!a) m_p--;
        end else if (a) begin
            if (m_p == 7) m_rej = 1;
            else m_p++;
        end
        if (latch) begin
            int nt;
            nt = (c == 0) ? 1 : c;
            if (nt != m_t) begin m_t = nt; m_rr = 0; end
        end
    endtask

    function automatic logic [18:0] model_vec();
        logic [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = (m_rem[i] > 0);
        return {3'(m_p), 2'(m_t), b, m_serve, 2'(m_sid), m_rej,
                m_p == 0, m_p == 7, 2'(m_t), 3'(m_p)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.pcount, bus.tcount, bus.busy, bus.serve,
                bus.serve_id, bus.reject, bus.ef, bus.ff, bus.index};
    endfunction

    task automatic step(input bit r, input bit a, input bit t, input int c);
        reset = r;
        bus.arrive = a;
        bus.tick = t;
        bus.tcount_cfg = 2'(c);
        @(posedge clk);
        model_step(r, a, t, c);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 3);
        tests++;
        if ({bus.ef, bus.ff, bus.index} !== {1'b1, 1'b0, 5'b01000}) begin
            fails++;
            $display("FAIL reset_flags got %b need %b",
                     {bus.ef, bus.ff, bus.index}, {1'b1, 1'b0, 5'b01000});
        end
        tests++;
        if ({bus.busy, bus.serve, bus.reject, bus.serve_id} !== 7'd0) begin
            fails++;
            $display("FAIL reset_state got %b need 0",
                     {bus.busy, bus.serve, bus.reject, bus.serve_id});
        end
    endtask

    task automatic test_two_tellers();
        logic [1:0] ids [2];
        int n = 0;
        int peak = 0;
        step(1, 0, 0, 2);
        step(0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 2);
            if (bus.serve && n < 2) begin ids[n] = bus.serve_id; n++; end
            if (int'(bus.pcount) > peak) peak = int'(bus.pcount);
        end
        tests++;
        if (n != 2 || ids[0] !== 2'd0 || ids[1] !== 2'd1) begin
            fails++;
            $display("FAIL two_tellers_ids got n=%0d %0d,%0d need 2 0,1",
                     n, ids[0], ids[1]);
        end
        tests++;
        if ({bus.pcount, bus.busy} !== {3'd1, 3'b011} || peak != 1) begin
            fails++;
            $display("FAIL two_tellers_state got p=%0d busy=%b peak=%0d need 1 011 1",
                     bus.pcount, bus.busy, peak);
        end
    endtask

    task automatic test_reject_full();
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1);
        tests++;
        if ({bus.pcount, bus.ff, bus.busy[0]} !== {3'd7, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL full got p=%0d ff=%b busy0=%b need 7 1 1",
                     bus.pcount, bus.ff, bus.busy[0]);
        end
        step(0, 1, 0, 1);
        tests++;
        if ({bus.reject, bus.pcount} !== {1'b1, 3'd7}) begin
            fails++;
            $display("FAIL reject got rej=%b p=%0d need 1 7",
                     bus.reject, bus.pcount);
        end
        for (int i = 0; i < ST; i++) step(0, 0, 1, 1);
        tests++;
        if (bus.busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL timer_clear got busy0=%b need 0", bus.busy[0]);
        end
        step(0, 0, 0, 1);
        tests++;
        if ({bus.serve, bus.pcount} !== {1'b1, 3'd6}) begin
            fails++;
            $display("FAIL serve_after_free got serve=%b p=%0d need 1 6",
                     bus.serve, bus.pcount);
        end
    endtask

    task automatic test_arrive_dispatch_full();
        step(0, 1, 0, 1);
        for (int i = 0; i < ST; i++) step(0, 0, 1, 1);
        step(0, 1, 0, 1);
        tests++;
        if ({bus.serve, bus.reject, bus.pcount, bus.ff} !==
            {1'b1, 1'b0, 3'd7, 1'b1}) begin
            fails++;
            $display("FAIL arrive_dispatch got s=%b r=%b p=%0d ff=%b need 1 0 7 1",
                     bus.serve, bus.reject, bus.pcount, bus.ff);
        end
    endtask

    task automatic test_round_robin();
        int bad = 0;
        step(1, 0, 0, 3);
        step(0, 0, 0, 3);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 3);
            step(0, 0, 0, 3);
            tests++;
            if (bus.serve !== 1'b1 || bus.serve_id !== 2'(k % 3)) begin
                fails++;
                $display("FAIL round_robin_%0d got s=%b id=%0d need 1 %0d",
                         k, bus.serve, bus.serve_id, k % 3);
            end
            for (int i = 0; i < ST; i++) step(0, 0, 1, 3);
        end
    endtask

    task automatic test_cfg_latch();
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 3);
        step(0, 0, 0, 3);
        tests++;
        if (bus.tcount !== 2'd1 || bus.busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL cfg_hold got t=%0d busy0=%b need 1 1",
                     bus.tcount, bus.busy[0]);
        end
        for (int i = 0; i < ST; i++) step(0, 0, 1, 3);
        step(0, 0, 0, 3);
        tests++;
        if (bus.index[4:3] !== 2'b11) begin
            fails++;
            $display("FAIL cfg_latch got %b need 11", bus.index[4:3]);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 3);
        step(0, 0, 0, 3);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 3);
        tests++;
        if ({bus.busy, bus.pcount} !== {3'b111, 3'd4}) begin
            fails++;
            $display("FAIL pre_reset got busy=%b p=%0d need 111 4",
                     bus.busy, bus.pcount);
        end
        step(1, 1, 1, 3);
        tests++;
        if ({bus.busy, bus.pcount, bus.ef, bus.index, bus.serve} !==
            {3'b000, 3'd0, 1'b1, 5'b01000, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid got %b need %b",
                     {bus.busy, bus.pcount, bus.ef, bus.index, bus.serve},
                     {3'b000, 3'd0, 1'b1, 5'b01000, 1'b0});
        end
        step(0, 0, 0, 3);
        tests++;
        if (bus.serve !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_serve got %b need 0", bus.serve);
        end
    endtask

    task automatic test_random();
        int cfg = 1;
        step(1, 0, 0, cfg);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) cfg = $urandom_range(0, 3);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 3) == 0, cfg);
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL random_cycle_%0d got %b need %b",
                         n, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.arrive = 1'b0;
        bus.tick = 1'b0;
        bus.tcount_cfg = 2'd0;
        test_reset();
        test_two_tellers();
        test_reject_full();
        test_arrive_dispatch_full();
        test_round_robin();
        test_cfg_latch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
